// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: default field widths,
// skid-buffer occupancy states and the payload layout.
package ex_mem_pkg;

    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_REG_AW       = 5;
    localparam int unsigned DEF_WB_W         = 2;
    localparam int unsigned DEF_MEM_W        = 3;
    localparam int unsigned DEF_REGWRITE_BIT = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [DEF_WB_W-1:0]   wb;
        logic [DEF_MEM_W-1:0]  mem;
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_DATA_W-1:0] rtdata;
        logic [DEF_REG_AW-1:0] writeaddr;
    } ex_mem_payload_t;

    // Total packed width of one payload entry for a given set of field widths.
    function automatic int unsigned payload_width(input int unsigned data_w,
                                                  input int unsigned reg_aw,
                                                  input int unsigned wb_w,
                                                  input int unsigned mem_w);
        return wb_w + mem_w + 2 * data_w + reg_aw;
    endfunction

endpackage

// File: rtl/stage_skid_buf.sv
// Generic two-entry skid buffer with flush. The main entry drives the outputs;
// the skid entry absorbs the one extra accept that can happen after the
// consumer stalls, so in_ready_o depends on registered state only.
//
//   state    | meaning
//   ST_EMPTY | nothing held, outputs invalid
//   ST_FULL  | main entry valid, skid free
//   ST_SKID  | main and skid valid, input stalled
module stage_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int unsigned PAY_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PAY_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PAY_W-1:0] out_data_o
);

    skid_state_e      state_q, state_d;
    logic [PAY_W-1:0] main_q, main_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic             accept;
    logic             take;

    assign in_ready_o  = (state_q != ST_SKID);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign accept      = in_valid_i & in_ready_o;
    assign take        = out_valid_o & out_ready_i;

    // Next-state and entry updates; flush overrides any accept or take.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data_i;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && take) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = ST_SKID;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (take) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and entry registers; reset clears both entries.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: packs the execute-stage payload into a skid buffer,
// turns an empty stage into a bubble (WB/MEM control forced to zero) and
// decodes the forwarding tap from the head entry.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned REG_AW       = DEF_REG_AW,
    parameter int unsigned WB_W         = DEF_WB_W,
    parameter int unsigned MEM_W        = DEF_MEM_W,
    parameter int unsigned REGWRITE_BIT = DEF_REGWRITE_BIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [MEM_W-1:0]  mem_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] rtdata_i,
    input  logic [REG_AW-1:0] writeaddr_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   wb_o,
    output logic [MEM_W-1:0]  mem_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] rtdata_o,
    output logic [REG_AW-1:0] writeaddr_o,
    output logic              fwd_en_o,
    output logic [REG_AW-1:0] fwd_addr_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam int unsigned PAY_W = payload_width(DATA_W, REG_AW, WB_W, MEM_W);

    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  head_pay;
    logic [WB_W-1:0]   head_wb;
    logic [MEM_W-1:0]  head_mem;

    assign in_pay = {wb_i, mem_i, result_i, rtdata_i, writeaddr_i};

    stage_skid_buf #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_pay),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (head_pay)
    );

    assign {head_wb, head_mem, result_o, rtdata_o, writeaddr_o} = head_pay;

    // An empty stage is a bubble: control fields read as zero while the
    // datapath fields keep their last value (the main entry is not rewritten).
    always_comb begin
        wb_o  = '0;
        mem_o = '0;
        if (out_valid_o) begin
            wb_o  = head_wb;
            mem_o = head_mem;
        end
    end

    // Forwarding tap: only a valid head that writes a nonzero register forwards.
    always_comb begin
        fwd_en_o   = out_valid_o & wb_o[REGWRITE_BIT] & (writeaddr_o != '0);
        fwd_addr_o = writeaddr_o;
        fwd_data_o = result_o;
    end

endmodule
